// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - tagged BTB + 2-bit PHT predictor with bimodal or gshare indexing
// Same-cycle lookup from fetch; MEM-stage training, GHR repair and mispredict counting.
module branch_predictor #(
  parameter int ENTRIES   = 64,
  parameter int HIST_BITS = 6,
  localparam int HW       = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pred_valid,
  input  logic          pred_stall,
  input  logic [31:0]   pred_pc,
  output logic          pred_hit,
  output logic          pred_taken,
  output logic [31:0]   pred_target,
  output logic [HW-1:0] pred_ghr,
  input  logic          upd_valid,
  input  logic [31:0]   upd_pc,
  input  logic          upd_taken,
  input  logic [31:0]   upd_target,
  input  logic [HW-1:0] upd_ghr,
  input  logic          upd_mispredict,
  output logic [31:0]   mispredict_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [ENTRIES-1:0] valid;
  logic [TAGW-1:0]    tag_mem    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [1:0]         pht        [ENTRIES];
  logic [HW-1:0]      ghr;
  logic [31:0]        mis_cnt;

  logic [IDX-1:0]  p_btb_idx, p_pht_idx, u_btb_idx, u_pht_idx;
  logic [TAGW-1:0] p_tag, u_tag;
  logic            unused_pc_lsb;

  // History is zero-extended into the index; bimodal mode contributes nothing.
  function automatic logic [IDX-1:0] hist_ext(input logic [HW-1:0] h);
    hist_ext = '0;
    if (HIST_BITS > 0) hist_ext[HW-1:0] = h;
  endfunction

  assign p_btb_idx = pred_pc[IDX+1:2];
  assign p_tag     = pred_pc[31:IDX+2];
  assign p_pht_idx = p_btb_idx ^ hist_ext(ghr);
  assign u_btb_idx = upd_pc[IDX+1:2];
  assign u_tag     = upd_pc[31:IDX+2];
  assign u_pht_idx = u_btb_idx ^ hist_ext(upd_ghr);
  assign unused_pc_lsb = ^upd_pc[1:0];

  assign pred_hit    = valid[p_btb_idx] & (tag_mem[p_btb_idx] == p_tag);
  assign pred_taken  = pred_hit & pht[p_pht_idx][1];
  assign pred_target = pred_taken ? btb_target[p_btb_idx] : pred_pc + 32'd4;
  assign pred_ghr    = ghr;
  assign mispredict_count = mis_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid[u_btb_idx] <= 1'b1;
        if (pht[u_pht_idx] != 2'b11) pht[u_pht_idx] <= pht[u_pht_idx] + 2'b01;
      end else if (pht[u_pht_idx] != 2'b00) begin
        pht[u_pht_idx] <= pht[u_pht_idx] - 2'b01;
      end
    end
  end

  // Tag and target need no reset: the valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_mem[u_btb_idx]    <= u_tag;
      btb_target[u_btb_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            mis_cnt <= '0;
    else if (upd_valid && upd_mispredict) mis_cnt <= mis_cnt + 32'd1;
  end

  generate
    if (HIST_BITS > 0) begin : g_gshare
      // Repair outranks the speculative shift: the younger fetch is on the wrong path.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          ghr <= '0;
        else if (upd_valid && upd_mispredict)
          ghr <= HW'({upd_ghr, upd_taken});
        else if (pred_valid && !pred_stall && pred_hit)
          ghr <= HW'({ghr, pred_taken});
      end
    end else begin : g_bimodal
      logic unused_hist;
      assign ghr = '0;
      assign unused_hist = ^{upd_ghr, pred_valid, pred_stall};
    end
  endgenerate

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized bench for branch_predictor (bimodal and gshare)
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid, pred_stall, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] pred_pc, upd_pc, upd_target;
  logic [5:0]  upd_ghr;

  logic        b_hit, b_taken, g_hit, g_taken;
  logic [31:0] b_target, g_target, b_cnt, g_cnt;
  logic [0:0]  b_ghr;
  logic [5:0]  g_ghr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .HIST_BITS(0)) dut_b (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_stall(pred_stall),
    .pred_pc(pred_pc), .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_target),
    .pred_ghr(b_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr[0:0]), .upd_mispredict(upd_mispredict),
    .mispredict_count(b_cnt));

  branch_predictor #(.ENTRIES(64), .HIST_BITS(6)) dut_g (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_stall(pred_stall),
    .pred_pc(pred_pc), .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target),
    .pred_ghr(g_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
    .mispredict_count(g_cnt));

  // Reference model: index 0 = bimodal instance, index 1 = gshare instance.
  bit          m_valid [2][64];
  int unsigned m_tag   [2][64];
  logic [31:0] m_tgt   [2][64];
  int          m_cnt   [2][64];
  int          m_ghr   [2];
  logic [31:0] m_mc    [2];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endfunction

  function automatic void look(input int m, input logic [31:0] pc,
                               output bit hit, output bit tk, output logic [31:0] tgt);
    int i, pi;
    i   = int'((pc >> 2) % 64);
    pi  = i ^ m_ghr[m];
    hit = m_valid[m][i] && (m_tag[m][i] == (pc >> 8));
    tk  = hit && (m_cnt[m][pi] >= 2);
    tgt = tk ? m_tgt[m][i] : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[m][i] = 0;
        m_cnt[m][i] = 1;
      end
      m_ghr[m] = 0;
      m_mc[m] = 0;
    end
  endfunction

  function automatic void model_step(input int m);
    bit h, t;
    logic [31:0] tg;
    int ui, pi;
    look(m, pred_pc, h, t, tg);
    if (upd_valid) begin
      ui = int'((upd_pc >> 2) % 64);
      pi = ui ^ ((m == 1) ? int'(upd_ghr) : 0);
      if (upd_taken) begin
        m_cnt[m][pi] = (m_cnt[m][pi] == 3) ? 3 : m_cnt[m][pi] + 1;
        m_valid[m][ui] = 1;
        m_tag[m][ui] = upd_pc >> 8;
        m_tgt[m][ui] = upd_target;
      end else begin
        m_cnt[m][pi] = (m_cnt[m][pi] == 0) ? 0 : m_cnt[m][pi] - 1;
      end
      if (upd_mispredict) m_mc[m] = m_mc[m] + 32'd1;
    end
    if (m == 1) begin
      if (upd_valid && upd_mispredict)
        m_ghr[m] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 64;
      else if (pred_valid && !pred_stall && h)
        m_ghr[m] = (m_ghr[m] * 2 + int'(t)) % 64;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    bit h, t;
    logic [31:0] tg;
    look(0, pred_pc, h, t, tg);
    chk("b_hit", {31'b0, b_hit}, {31'b0, h});
    chk("b_taken", {31'b0, b_taken}, {31'b0, t});
    chk("b_target", b_target, tg);
    chk("b_ghr", {31'b0, b_ghr}, 32'(m_ghr[0]));
    chk("b_count", b_cnt, m_mc[0]);
    look(1, pred_pc, h, t, tg);
    chk("g_hit", {31'b0, g_hit}, {31'b0, h});
    chk("g_taken", {31'b0, g_taken}, {31'b0, t});
    chk("g_target", g_target, tg);
    chk("g_ghr", {26'b0, g_ghr}, 32'(m_ghr[1]));
    chk("g_count", g_cnt, m_mc[1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic [5:0] gh, input logic mis);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tg;
    upd_ghr = gh;
    upd_mispredict = mis;
  endtask

  task automatic no_upd();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    pred_valid = 0; pred_stall = 0; pred_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_ghr = 0; upd_mispredict = 0;
    repeat (2) step();
    reset = 0;
    pred_valid = 1; pred_pc = 32'h100;
    probe();
    chk("lit_reset_hit", {31'b0, b_hit}, 32'd0);
    chk("lit_reset_taken", {31'b0, b_taken}, 32'd0);
    chk("lit_reset_target", b_target, 32'h104);
    chk("lit_reset_count", b_cnt, 32'd0);

    step(); upd(32'h100, 1, 32'h80, 6'd0, 1);
    probe();
    chk("lit_same_cycle_hit", {31'b0, b_hit}, 32'd0);
    step(); no_upd();
    probe();
    chk("lit_install_hit", {31'b0, b_hit}, 32'd1);
    chk("lit_install_taken", {31'b0, b_taken}, 32'd1);
    chk("lit_install_target", b_target, 32'h80);
    chk("lit_install_count", b_cnt, 32'd1);

    repeat (4) begin step(); upd(32'h100, 1, 32'h80, 6'd0, 0); end
    step(); upd(32'h100, 0, 32'h0, 6'd0, 0);
    step(); no_upd();
    probe();
    chk("lit_sat_weak_taken", {31'b0, b_taken}, 32'd1);
    repeat (2) begin step(); upd(32'h100, 0, 32'h0, 6'd0, 0); end
    step(); no_upd();
    probe();
    chk("lit_sat_hit", {31'b0, b_hit}, 32'd1);
    chk("lit_sat_not_taken", {31'b0, b_taken}, 32'd0);
    chk("lit_sat_target", b_target, 32'h104);

    step(); upd(32'h100, 1, 32'h80, 6'd0, 0);
    step(); upd(32'h200, 1, 32'h40, 6'd0, 0);
    step(); no_upd(); pred_pc = 32'h100;
    probe();
    chk("lit_alias_old_hit", {31'b0, b_hit}, 32'd0);
    step(); pred_pc = 32'h200;
    probe();
    chk("lit_alias_new_hit", {31'b0, b_hit}, 32'd1);
    chk("lit_alias_new_target", b_target, 32'h40);

    step(); reset = 1;
    step(); reset = 0; pred_valid = 0;
    foreach (upd_ghr_seed[k]) begin step(); upd(32'h100, 1, 32'h80, upd_ghr_seed[k], 0); end
    step(); no_upd(); pred_valid = 1; pred_pc = 32'h100;
    probe();
    chk("lit_ghr_start", {26'b0, g_ghr}, 32'd0);
    step(); step(); step(); pred_stall = 1;
    probe();
    chk("lit_ghr_three_taken", {26'b0, g_ghr}, 32'h07);
    step(); pred_stall = 0; upd(32'h100, 0, 32'h0, 6'b000101, 1);
    probe();
    chk("lit_ghr_stalled", {26'b0, g_ghr}, 32'h07);
    step(); no_upd(); pred_valid = 0;
    probe();
    chk("lit_ghr_repair", {26'b0, g_ghr}, 32'h0A);

    force dut_b.mis_cnt = 32'hFFFF_FFFF;
    #1 release dut_b.mis_cnt;
    m_mc[0] = 32'hFFFF_FFFF;
    step(); upd(32'h300, 1, 32'h44, 6'd0, 1);
    step(); no_upd();
    probe();
    chk("lit_count_wrap", b_cnt, 32'd0);

    step(); pred_valid = 1; pred_pc = 32'h300;
    #2 reset = 1;
    #1;
    chk("lit_async_b_hit", {31'b0, b_hit}, 32'd0);
    chk("lit_async_b_taken", {31'b0, b_taken}, 32'd0);
    chk("lit_async_b_target", b_target, 32'h304);
    chk("lit_async_g_hit", {31'b0, g_hit}, 32'd0);
    chk("lit_async_g_ghr", {26'b0, g_ghr}, 32'd0);
    chk("lit_async_g_count", g_cnt, 32'd0);
    step(); reset = 0;

    for (int n = 0; n < 3000; n++) begin
      step();
      pred_valid = ($urandom_range(3) != 0);
      pred_stall = ($urandom_range(3) == 0);
      pred_pc = ($urandom_range(3) << 8) | ($urandom_range(7) << 2);
      if ($urandom_range(1) == 1)
        upd(($urandom_range(3) << 8) | ($urandom_range(7) << 2), 1'($urandom_range(1)),
            $urandom & 32'hFFFF_FFFC, 6'($urandom_range(63)), ($urandom_range(9) < 3));
      else
        no_upd();
      reset = ($urandom_range(499) == 0);
    end
    step(); reset = 0; no_upd();
    probe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [5:0] upd_ghr_seed [3] = '{6'd0, 6'd1, 6'd3};

endmodule
